fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning address/PC width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning number of queue entries, power of two, at least 2.
REQ-003 The block SHALL have parameter FETCH_W, default 64, meaning fetch bundle width (two 32-bit instructions).
REQ-004 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port flush_i, input, 1 bit, discarding all queued and in-flight bundles (branch redirect).
REQ-007 The block SHALL have port pc_valid_i, input, 1 bit, meaning a fetch PC is offered.
REQ-008 The block SHALL have port pc_i, input, XLEN bits, the offered fetch PC.
REQ-009 The block SHALL have port stall_o, output, 1 bit, back-pressure to the fetch stage; high means the PC is not accepted.
REQ-010 The block SHALL have port imem_req_o, output, 1 bit, the instruction-memory request strobe.
REQ-011 The block SHALL have port imem_addr_o, output, XLEN bits, the bundle-aligned request address.
REQ-012 The block SHALL have port imem_rvalid_i, input, 1 bit, the in-order response strobe with latency of 1 or more cycles.
REQ-013 The block SHALL have port imem_rdata_i, input, FETCH_W bits, the response bundle.
REQ-014 The block SHALL have port dec_valid_o, output, 1 bit, meaning a bundle is presented to decode.
REQ-015 The block SHALL have port dec_pc_o, output, XLEN bits, the PC of the presented bundle.
REQ-016 The block SHALL have port dec_instr_o, output, FETCH_W bits, the presented bundle.
REQ-017 The block SHALL have port dec_ready_i, input, 1 bit; decode consumes the bundle when dec_valid_o and dec_ready_i are both high.

Function
REQ-018 The block SHALL be a circular queue with alloc, fill and head pointers; each entry holds pc, instr and filled.
REQ-019 The block SHALL drive stall_o = (count == DEPTH) | flush_i, decoded from registers and flush_i only, with no path from dec_ready_i.
REQ-020 Accept SHALL be pc_valid_i & ~stall_o; on accept, in the same cycle, the block SHALL assert imem_req_o=1 and imem_addr_o={pc_i[XLEN-1:3],3'b000}, and write pc_i to entry[alloc] with filled=0.
REQ-021 On imem_rvalid_i with drop_cnt==0, the block SHALL write imem_rdata_i to entry[fill], set filled=1 and advance fill.
REQ-022 dec_valid_o SHALL equal entry[head].filled & (count!=0); response-to-dec_valid_o latency is 1 cycle; there is no bypass.
REQ-023 On a handshake the block SHALL clear entry[head].filled and advance head.
REQ-024 Allocation and pop in the same cycle SHALL leave count unchanged; while full, a pop in cycle N SHALL permit an accept in cycle N+1.
REQ-025 All pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-026 On flush_i, the block SHALL on the next edge reset head, fill, alloc and count to 0, clear all filled bits, and load drop_cnt with the number of requests issued but not yet responded, including one issued in the flush cycle.
REQ-027 While drop_cnt>0, each imem_rvalid_i SHALL be discarded and decrement drop_cnt; new accepts are allowed during this time.
REQ-028 Flush coincident with rvalid SHALL count that response as already returned, not as one to drop.
REQ-029 imem_rvalid_i with no outstanding request SHALL be ignored; the bench flags it as a protocol error.
REQ-030 dec_pc_o and dec_instr_o SHALL equal entry[head] contents.

Reset
REQ-031 While rst_ni is low, the block SHALL asynchronously clear pointers, count, drop_cnt and all filled bits.
REQ-032 After reset, outputs SHALL be stall_o=0, imem_req_o=0, imem_addr_o=0, dec_valid_o=0, dec_pc_o=0 and dec_instr_o=0; entry pc/instr storage need not be reset.
REQ-033 Reset asserted mid-operation SHALL abandon in-flight requests without drop tracking; the memory side is reset by the same rst_ni.

Structure
REQ-034 Package fetch_pkg SHALL hold FETCH_BYTES=8, FETCH_W, and typedef fetch_entry_t {pc, instr, filled}.
REQ-035 The block SHALL be implemented flat with no sub-module; pointer width is $clog2(DEPTH) and count/drop_cnt width is $clog2(DEPTH)+1.

Verification
REQ-036 Streaming: PCs 0x0,0x8,0x10 accepted; 1-cycle memory; dec_ready_i=1 -> bundles are presented in order, each one cycle after rvalid, and stall_o stays 0.
REQ-037 Full: dec_ready_i=0, 4 accepts -> stall_o=1 with count=4; dec_ready_i=1 for one cycle -> stall_o=0 on the next cycle.
REQ-038 Wrap: 10 PCs with random dec_ready_i -> order and pc/instr pairing are preserved across pointer wrap.
REQ-039 Flush with 2 in flight (3-cycle latency), then PC 0x100 -> the first 2 responses are dropped and only 0x100's bundle reaches decode.
REQ-040 Flush in the same cycle as rvalid and an accept -> drop_cnt equals the outstanding count excluding the returning response, and no stale bundle appears.
REQ-041 Reset asserted while dec_valid_o=1 -> all outputs are 0 immediately, and operation resumes cleanly after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the queue-entry record used by fetch_buffer.
package fetch_pkg;

  localparam int FETCH_BYTES = 8;
  localparam int FETCH_W     = 64;

  // Widest PC the entry record can hold; narrower XLEN values are zero-extended.
  localparam int PC_MAX_W    = 64;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [FETCH_W-1:0]  instr;
    logic                filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order circular queue between the fetch PC stage, the
// instruction memory and decode. Entries are allocated when a PC is accepted
// and the memory request is issued. They are filled in order as responses
// return, and popped by decode. A flush empties the queue and counts the
// responses still owed by memory so that they can be discarded on arrival.
module fetch_buffer
  import fetch_pkg::FETCH_BYTES, fetch_pkg::PC_MAX_W, fetch_pkg::fetch_entry_t;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int FETCH_W = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               pc_valid_i,
  input  logic [XLEN-1:0]    pc_i,
  output logic               stall_o,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_rvalid_i,
  input  logic [FETCH_W-1:0] imem_rdata_i,
  output logic               dec_valid_o,
  output logic [XLEN-1:0]    dec_pc_o,
  output logic [FETCH_W-1:0] dec_instr_o,
  input  logic               dec_ready_i
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int OFF_W   = $clog2(FETCH_BYTES);
  localparam int INSTR_W = fetch_pkg::FETCH_W;

  fetch_entry_t     entry_reg [DEPTH];

  logic [PTR_W-1:0] head_reg,  head_next;
  logic [PTR_W-1:0] fill_reg,  fill_next;
  logic [PTR_W-1:0] alloc_reg, alloc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  // Requests issued for live entries that have not returned yet.
  logic [CNT_W-1:0] pend_reg,  pend_next;
  // Responses still owed for requests abandoned by a flush.
  logic [CNT_W-1:0] drop_reg,  drop_next;

  logic             accept;
  logic             pop;
  logic             rsp_drop;
  logic             rsp_fill;
  logic             rsp_counted;
  logic [CNT_W:0]   outstanding;

  // Back-pressure depends only on registered occupancy and flush.
  assign stall_o     = (count_reg == CNT_W'(DEPTH)) | flush_i;
  assign accept      = pc_valid_i & ~stall_o;

  assign imem_req_o  = accept;
  assign imem_addr_o = accept ? {pc_i[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;

  assign dec_valid_o = entry_reg[head_reg].filled & (count_reg != '0);
  assign dec_pc_o    = XLEN'(entry_reg[head_reg].pc);
  assign dec_instr_o = FETCH_W'(entry_reg[head_reg].instr);
  assign pop         = dec_valid_o & dec_ready_i;

  // Abandoned requests are always older than live ones, so they drain first.
  assign rsp_drop    = imem_rvalid_i & (drop_reg != '0);
  assign rsp_fill    = imem_rvalid_i & (drop_reg == '0) & (pend_reg != '0);
  assign rsp_counted = rsp_drop | rsp_fill;

  // A response arriving in the flush cycle has already returned and is not
  // owed any more. A stray response has no effect.
  assign outstanding = {1'b0, drop_reg} + {1'b0, pend_reg}
                     + (CNT_W+1)'(accept) - (CNT_W+1)'(rsp_counted);

  // Next-state for pointers and counters; flush overrides all queue activity.
  always_comb begin
    head_next  = head_reg;
    fill_next  = fill_reg;
    alloc_next = alloc_reg;
    count_next = count_reg;
    pend_next  = pend_reg;
    drop_next  = drop_reg;
    if (flush_i) begin
      head_next  = '0;
      fill_next  = '0;
      alloc_next = '0;
      count_next = '0;
      pend_next  = '0;
      drop_next  = outstanding[CNT_W] ? '1 : outstanding[CNT_W-1:0];
    end else begin
      if (pop) begin
        head_next = head_reg + PTR_W'(1);
      end
      if (rsp_fill) begin
        fill_next = fill_reg + PTR_W'(1);
      end
      if (accept) begin
        alloc_next = alloc_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(accept) - CNT_W'(pop);
      pend_next  = pend_reg + CNT_W'(accept) - CNT_W'(rsp_fill);
      drop_next  = drop_reg - CNT_W'(rsp_drop);
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_reg  <= '0;
      fill_reg  <= '0;
      alloc_reg <= '0;
      count_reg <= '0;
      pend_reg  <= '0;
      drop_reg  <= '0;
    end else begin
      head_reg  <= head_next;
      fill_reg  <= fill_next;
      alloc_reg <= alloc_next;
      count_reg <= count_next;
      pend_reg  <= pend_next;
      drop_reg  <= drop_next;
    end
  end

  // Entry storage. Alloc, fill and pop never address the same slot in one
  // cycle, so their writes are independent. Contents are cleared on reset so
  // that the decode outputs read as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_i) begin
          entry_reg[i].filled <= 1'b0;
        end else begin
          if (accept && (alloc_reg == PTR_W'(i))) begin
            entry_reg[i].pc     <= PC_MAX_W'(pc_i);
            entry_reg[i].filled <= 1'b0;
          end
          if (rsp_fill && (fill_reg == PTR_W'(i))) begin
            entry_reg[i].instr  <= INSTR_W'(imem_rdata_i);
            entry_reg[i].filled <= 1'b1;
          end
          if (pop && (head_reg == PTR_W'(i))) begin
            entry_reg[i].filled <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed tests for fetch_buffer. These include streaming,
// full and back-pressure, pointer wrap, flush while requests are in flight,
// flush together with a response, mid-run reset and a stray response.
// A transaction-level model (a queue of entries and a list of owed responses)
// predicts every output each cycle.
module tb_fetch_buffer;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int FETCH_W = 64;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               flush_i = 1'b0;
  logic               pc_valid_i = 1'b0;
  logic [XLEN-1:0]    pc_i = '0;
  logic               stall_o;
  logic               imem_req_o;
  logic [XLEN-1:0]    imem_addr_o;
  logic               imem_rvalid_i = 1'b0;
  logic [FETCH_W-1:0] imem_rdata_i = '0;
  logic               dec_valid_o;
  logic [XLEN-1:0]    dec_pc_o;
  logic [FETCH_W-1:0] dec_instr_o;
  logic               dec_ready_i = 1'b0;

  fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .FETCH_W(FETCH_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .pc_valid_i(pc_valid_i), .pc_i(pc_i), .stall_o(stall_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .dec_valid_o(dec_valid_o), .dec_pc_o(dec_pc_o), .dec_instr_o(dec_instr_o),
    .dec_ready_i(dec_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;
  bit stray   = 1'b0;
  bit chk_en  = 1'b0;
  int proto_err = 0;

  logic [31:0] got_pc[$];
  logic [63:0] got_instr[$];
  logic [31:0] exp_q[$];

  function automatic logic [63:0] mem_fn(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- memory: fixed latency, in order ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];

  always @(negedge clk_i) begin
    if (!rst_ni) mem_q.delete();
    else if (imem_req_o === 1'b1) mem_q.push_back('{imem_addr_o, cyc + lat});
  end

  always @(posedge clk_i) begin
    mreq_t r;
    #2;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (rst_ni) begin
      if (stray) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        r = mem_q.pop_front();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_fn(r.addr);
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [63:0] instr;
    bit          filled;
  } ment_t;
  ment_t mq[$];
  bit    live_q[$];   // one flag per owed response: 1 = still wanted

  always @(posedge clk_i or negedge rst_ni) begin
    bit m_stall, m_acc, m_pop, done;
    if (!rst_ni) begin
      mq.delete();
      live_q.delete();
    end else begin
      m_stall = (mq.size() == DEPTH) || flush_i;
      m_acc   = pc_valid_i && !m_stall;
      m_pop   = (mq.size() > 0) && mq[0].filled && dec_ready_i;
      if (imem_rvalid_i) begin
        if (live_q.size() == 0) begin
          proto_err++;
          $display("[TB] cycle %0d: protocol error, response with nothing outstanding", cyc);
        end else if (live_q.pop_front()) begin
          done = 1'b0;
          for (int i = 0; i < mq.size(); i++) begin
            if (!done && !mq[i].filled) begin
              mq[i].filled = 1'b1;
              mq[i].instr  = mem_fn({mq[i].pc[31:3], 3'b000});
              done = 1'b1;
            end
          end
        end
      end
      if (flush_i) begin
        foreach (live_q[i]) live_q[i] = 1'b0;
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_acc) begin
          mq.push_back('{pc_i, 64'h0, 1'b0});
          live_q.push_back(1'b1);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    bit exp_stall, exp_req, exp_dv;
    if (rst_ni && chk_en) begin
      exp_stall = (mq.size() == DEPTH) || flush_i;
      exp_req   = pc_valid_i && !exp_stall;
      exp_dv    = (mq.size() > 0) && mq[0].filled;
      chk("stall_o", 64'(stall_o), 64'(exp_stall));
      chk("imem_req_o", 64'(imem_req_o), 64'(exp_req));
      if (exp_req) chk("imem_addr_o", 64'(imem_addr_o), 64'({pc_i[31:3], 3'b000}));
      chk("dec_valid_o", 64'(dec_valid_o), 64'(exp_dv));
      if (exp_dv) begin
        chk("dec_pc_o", 64'(dec_pc_o), 64'(mq[0].pc));
        chk("dec_instr_o", dec_instr_o, mq[0].instr);
      end
      if (dec_valid_o && dec_ready_i) begin
        got_pc.push_back(dec_pc_o);
        got_instr.push_back(dec_instr_o);
        $display("[TB] cycle %0d: decode took pc=0x%08h instr=0x%016h", cyc, dec_pc_o, dec_instr_o);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int k = 0;
    while (got_pc.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(got_pc.size()), 64'(n));
  endtask

  task automatic check_list(input string tag);
    chk({tag, " count"}, 64'(got_pc.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_pc.size()) chk($sformatf("%s pc[%0d]", tag, i), 64'(got_pc[i]), 64'(exp_q[i]));
    end
    got_pc.delete();
    got_instr.delete();
    exp_q.delete();
  endtask

  task automatic offer(input logic [31:0] pc);
    pc_valid_i = 1'b1;
    pc_i = pc;
    tick();
    pc_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int guard;
    logic [31:0] pc;

    // Reset state.
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset stall_o", 64'(stall_o), 64'd0);
    chk("reset imem_req_o", 64'(imem_req_o), 64'd0);
    chk("reset imem_addr_o", 64'(imem_addr_o), 64'd0);
    chk("reset dec_valid_o", 64'(dec_valid_o), 64'd0);
    chk("reset dec_pc_o", 64'(dec_pc_o), 64'd0);
    chk("reset dec_instr_o", dec_instr_o, 64'd0);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    tick();

    // Streaming with 1-cycle memory.
    lat = 1;
    dec_ready_i = 1'b1;
    pc_valid_i = 1'b1;
    pc_i = 32'h0;  tick();
    pc_i = 32'h8;  tick();
    pc_i = 32'h10; tick();
    pc_valid_i = 1'b0;
    run_until(3, 30, "stream drain");
    if (got_instr.size() > 0) chk("stream instr[0]", got_instr[0], 64'hA5A5_0000_FFFF_FFFF);
    exp_q.push_back(32'h0); exp_q.push_back(32'h8); exp_q.push_back(32'h10);
    check_list("stream");

    // Full queue, then a single pop releases the stall next cycle.
    dec_ready_i = 1'b0;
    pc_valid_i = 1'b1;
    pc_i = 32'h20; tick();
    pc_i = 32'h28; tick();
    pc_i = 32'h30; tick();
    pc_i = 32'h38; tick();
    pc_valid_i = 1'b0;
    repeat (3) tick();
    chk("full stall_o", 64'(stall_o), 64'd1);
    chk("full dec_valid_o", 64'(dec_valid_o), 64'd1);
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
    chk("stall after one pop", 64'(stall_o), 64'd0);
    dec_ready_i = 1'b1;
    run_until(4, 30, "full drain");
    exp_q.push_back(32'h20); exp_q.push_back(32'h28);
    exp_q.push_back(32'h30); exp_q.push_back(32'h38);
    check_list("full");

    // Pointer wrap with random decode back-pressure; odd PCs are unaligned.
    lat = 2;
    for (int i = 0; i < 10; i++) begin
      pc = 32'h1000 + 32'(8 * i) + ((i % 2 == 1) ? 32'h4 : 32'h0);
      exp_q.push_back(pc);
      pc_valid_i = 1'b1;
      pc_i = pc;
      guard = 0;
      do begin
        dec_ready_i = 1'($urandom_range(0, 1));
        acc = !stall_o;
        tick();
        guard++;
      end while (!acc && guard < 50);
    end
    pc_valid_i = 1'b0;
    dec_ready_i = 1'b1;
    run_until(10, 60, "wrap drain");
    check_list("wrap");

    // Flush with two requests in flight (3-cycle memory), then PC 0x100.
    lat = 3;
    dec_ready_i = 1'b1;
    pc_valid_i = 1'b1;
    pc_i = 32'h200; tick();
    pc_i = 32'h208; tick();
    pc_valid_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    offer(32'h100);
    run_until(1, 30, "flush drain");
    repeat (6) tick();
    exp_q.push_back(32'h100);
    check_list("flush");

    // Flush in the same cycle as a response and an offered PC.
    lat = 2;
    dec_ready_i = 1'b0;
    pc_valid_i = 1'b1;
    pc_i = 32'h300; tick();
    pc_i = 32'h308; tick();
    flush_i = 1'b1;
    pc_i = 32'h310;
    #1;
    chk("flush blocks accept", 64'(imem_req_o), 64'd0);
    chk("flush forces stall", 64'(stall_o), 64'd1);
    tick();
    flush_i = 1'b0;
    pc_i = 32'h318;
    tick();
    pc_valid_i = 1'b0;
    dec_ready_i = 1'b1;
    run_until(1, 30, "flush+rvalid drain");
    repeat (6) tick();
    if (got_instr.size() > 0) chk("flush+rvalid instr", got_instr[0], 64'hA5A5_0318_FFFF_FCE7);
    exp_q.push_back(32'h318);
    check_list("flush+rvalid");

    // Reset while a bundle is presented.
    lat = 1;
    dec_ready_i = 1'b0;
    offer(32'h400);
    repeat (3) tick();
    chk("pre-reset dec_valid_o", 64'(dec_valid_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid-reset stall_o", 64'(stall_o), 64'd0);
    chk("mid-reset imem_req_o", 64'(imem_req_o), 64'd0);
    chk("mid-reset imem_addr_o", 64'(imem_addr_o), 64'd0);
    chk("mid-reset dec_valid_o", 64'(dec_valid_o), 64'd0);
    chk("mid-reset dec_pc_o", 64'(dec_pc_o), 64'd0);
    chk("mid-reset dec_instr_o", dec_instr_o, 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    dec_ready_i = 1'b1;
    offer(32'h500);
    run_until(1, 30, "post-reset drain");
    exp_q.push_back(32'h500);
    check_list("post-reset");

    // Stray response with nothing outstanding must be ignored.
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    chk("stray dec_valid_o", 64'(dec_valid_o), 64'd0);
    offer(32'h600);
    run_until(1, 30, "stray drain");
    if (got_instr.size() > 0) chk("stray instr", got_instr[0], 64'hA5A5_0600_FFFF_F9FF);
    exp_q.push_back(32'h600);
    check_list("stray");

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
